shift_reg_input: RTL and testbench

Reads a 74HC165 parallel-in/serial-out shift register, the input-side counterpart of the 74HC595 output driver. A toggle on the request input starts one read cycle. The block pulses the parallel-load line low, then clocks the bits out MSB-first. It publishes the captured word with a completion toggle. It sits between board-level switch/button banks and user logic, on the same 16 MHz single clock domain.

---
 rtl/shift_reg_input_pkg.sv | 15 +
 rtl/sync_2ff.sv | 24 ++
 rtl/shift_reg_input.sv | 115 +++++++++++
 tb/tb_shift_reg_input.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_input_pkg.sv
// Shared constants for the 74HC165 reader.
// Holds the FSM state encoding and the synchroniser depth.
package shift_reg_input_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SAMPLE   = 3'd2,
    CLK_HIGH = 3'd3,
    DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit flop-chain synchroniser for asynchronous pin inputs.
// Async active-low reset clears every stage.
module sync_2ff
  import shift_reg_input_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      q <= '0;
    end else begin
      q <= {q[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = q[SYNC_STAGES-1];

endmodule

// File: rtl/shift_reg_input.sv
// 74HC165 reader: toggle-requested parallel load, MSB-first serial shift,
// completed word published with a done toggle.
module shift_reg_input
  import shift_reg_input_pkg::*;
#(
  parameter int DATA_WIDTH  = 3,
  parameter int PHASE_TICKS = 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_sample_toggle,
  input  logic                       i_data_val,
  output logic                       o_load_n,
  output logic                       o_data_clock,
  output logic [(1<<DATA_WIDTH)-1:0] o_value,
  output logic                       o_done_toggle,
  output logic                       o_busy
);

  localparam int DATA_SIZE = 1 << DATA_WIDTH;
  localparam int BW        = DATA_WIDTH + 1;
  // One bit beyond 8 so the settle window still fits at PHASE_TICKS=255.
  localparam int PW        = 9;

  localparam logic [PW-1:0] PH_LAST  = PW'(PHASE_TICKS - 1);
  localparam logic [PW-1:0] SMP_LAST = PW'(PHASE_TICKS + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_SIZE - 1);

  state_t                 state;
  logic [PW-1:0]          phase;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_SIZE-1:0]   shift_value;
  logic                   last_toggle;
  logic                   sync_data;

  sync_2ff u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_data_val),
    .o_q       (sync_data)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      phase         <= '0;
      bit_cnt       <= '0;
      shift_value   <= '0;
      last_toggle   <= 1'b0;
      o_load_n      <= 1'b1;
      o_data_clock  <= 1'b0;
      o_value       <= '0;
      o_done_toggle <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          o_load_n     <= 1'b1;
          o_data_clock <= 1'b0;
          o_busy       <= 1'b0;
          phase        <= '0;
          if (i_sample_toggle != last_toggle) begin
            last_toggle <= i_sample_toggle;
            bit_cnt     <= '0;
            o_busy      <= 1'b1;
            o_load_n    <= 1'b0;
            state       <= LOAD;
          end
        end
        LOAD: begin
          if (phase == PH_LAST) begin
            phase    <= '0;
            o_load_n <= 1'b1;
            state    <= SAMPLE;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        SAMPLE: begin
          if (phase == SMP_LAST) begin
            phase       <= '0;
            shift_value <= {shift_value[DATA_SIZE-2:0], sync_data};
            bit_cnt     <= bit_cnt + BW'(1);
            // No CP pulse after the final bit.
            if (bit_cnt == BIT_LAST) begin
              state <= DONE;
            end else begin
              o_data_clock <= 1'b1;
              state        <= CLK_HIGH;
            end
          end else begin
            phase <= phase + PW'(1);
          end
        end
        CLK_HIGH: begin
          if (phase == PH_LAST) begin
            phase        <= '0;
            o_data_clock <= 1'b0;
            state        <= SAMPLE;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        DONE: begin
          o_value       <= shift_value;
          o_done_toggle <= ~o_done_toggle;
          o_busy        <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_input.sv
// Directed bench for shift_reg_input with a behavioural 74HC165 per DUT.
// Three instances: default, PHASE_TICKS=4, DATA_WIDTH=4.
module tb_shift_reg_input;

  logic clk = 1'b0;
  always #31 clk = ~clk;

  logic [2:0]  rst_n, tog, ld, cp, busy, done, q7;
  logic [7:0]  val0, val1, par0, par1, sr0, sr1;
  logic [15:0] val2, par2, sr2;

  int ldc [3];
  int cph [3];
  int rise0, rise1, rise2;
  int errors = 0;
  int checks = 0;

  shift_reg_input u0 (
    .i_clk(clk), .i_reset_n(rst_n[0]), .i_sample_toggle(tog[0]),
    .i_data_val(q7[0]), .o_load_n(ld[0]), .o_data_clock(cp[0]),
    .o_value(val0), .o_done_toggle(done[0]), .o_busy(busy[0])
  );

  shift_reg_input #(.PHASE_TICKS(4)) u1 (
    .i_clk(clk), .i_reset_n(rst_n[1]), .i_sample_toggle(tog[1]),
    .i_data_val(q7[1]), .o_load_n(ld[1]), .o_data_clock(cp[1]),
    .o_value(val1), .o_done_toggle(done[1]), .o_busy(busy[1])
  );

  shift_reg_input #(.DATA_WIDTH(4)) u2 (
    .i_clk(clk), .i_reset_n(rst_n[2]), .i_sample_toggle(tog[2]),
    .i_data_val(q7[2]), .o_load_n(ld[2]), .o_data_clock(cp[2]),
    .o_value(val2), .o_done_toggle(done[2]), .o_busy(busy[2])
  );

  // 74HC165 models: PL low loads, CP rise shifts toward Q7.
  always @(negedge ld[0] or posedge cp[0])
    if (!ld[0]) sr0 <= par0; else sr0 <= {sr0[6:0], 1'b0};
  always @(negedge ld[1] or posedge cp[1])
    if (!ld[1]) sr1 <= par1; else sr1 <= {sr1[6:0], 1'b0};
  always @(negedge ld[2] or posedge cp[2])
    if (!ld[2]) sr2 <= par2; else sr2 <= {sr2[14:0], 1'b0};

  assign q7 = {sr2[15], sr1[7], sr0[7]};

  always @(posedge clk)
    for (int k = 0; k < 3; k++) begin
      if (ld[k] === 1'b0) ldc[k]++;
      if (cp[k] === 1'b1) cph[k]++;
    end

  always @(posedge cp[0]) rise0++;
  always @(posedge cp[1]) rise1++;
  always @(posedge cp[2]) rise2++;

  function automatic int lat(input int p, input int s);
    return p + s * (p + 2) + (s - 1) * p + 1;
  endfunction

  task automatic kick(input int k);
    @(posedge clk);
    #1 tog[k] = ~tog[k];
  endtask

  task automatic wait_done(input int k, input int limit, output int n);
    logic p;
    p = done[k];
    n = 0;
    while (n < limit) begin
      @(posedge clk);
      n++;
      #1;
      if (done[k] !== p) break;
    end
  endtask

  task automatic test_reset;
    int l, r;
    rst_n = '0;
    #200;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ld[k] !== 1'b1) begin
        errors++; $display("FAIL rst_load_n[%0d]: got %b want 1", k, ld[k]);
      end
      checks++;
      if (cp[k] !== 1'b0) begin
        errors++; $display("FAIL rst_cp[%0d]: got %b want 0", k, cp[k]);
      end
      checks++;
      if (busy[k] !== 1'b0) begin
        errors++; $display("FAIL rst_busy[%0d]: got %b want 0", k, busy[k]);
      end
      checks++;
      if (done[k] !== 1'b0) begin
        errors++; $display("FAIL rst_done[%0d]: got %b want 0", k, done[k]);
      end
    end
    checks++;
    if ({val2, val1, val0} !== 32'h0) begin
      errors++;
      $display("FAIL rst_value: got %h want 0", {val2, val1, val0});
    end
    @(negedge clk);
    rst_n = '1;
    l = ldc[0];
    r = rise0;
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (ldc[0] - l !== 0 || rise0 - r !== 0) begin
      errors++;
      $display("FAIL idle_quiet: got load=%0d cp=%0d want 0 0",
               ldc[0] - l, rise0 - r);
    end
    checks++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_flags: got done=%b busy=%b want 0 0",
               done[0], busy[0]);
    end
  endtask

  task automatic test_basic;
    int l, r, n;
    par0 = 8'hA5;
    l = ldc[0];
    r = rise0;
    kick(0);
    @(posedge clk);
    #1;
    checks++;
    if (busy[0] !== 1'b1 || ld[0] !== 1'b0) begin
      errors++;
      $display("FAIL accept: got busy=%b load_n=%b want 1 0", busy[0], ld[0]);
    end
    wait_done(0, 100, n);
    n = n + 1;
    checks++;
    if (n !== lat(1, 8) + 1) begin
      errors++; $display("FAIL basic_latency: got %0d want %0d", n, lat(1, 8) + 1);
    end
    checks++;
    if (val0 !== 8'hA5) begin
      errors++; $display("FAIL basic_value: got %h want a5", val0);
    end
    checks++;
    if (ldc[0] - l !== 1 || rise0 - r !== 7) begin
      errors++;
      $display("FAIL basic_pins: got load=%0d cp=%0d want 1 7",
               ldc[0] - l, rise0 - r);
    end
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++; $display("FAIL basic_busy: got %b want 0", busy[0]);
    end
  endtask

  task automatic test_phase4;
    int l, h, r, n;
    par1 = 8'h81;
    l = ldc[1];
    h = cph[1];
    r = rise1;
    kick(1);
    wait_done(1, 200, n);
    checks++;
    if (n !== lat(4, 8) + 1) begin
      errors++; $display("FAIL p4_latency: got %0d want %0d", n, lat(4, 8) + 1);
    end
    checks++;
    if (val1 !== 8'h81) begin
      errors++; $display("FAIL p4_value: got %h want 81", val1);
    end
    checks++;
    if (ldc[1] - l !== 4 || cph[1] - h !== 28 || rise1 - r !== 7) begin
      errors++;
      $display("FAIL p4_pins: got load=%0d cphi=%0d cp=%0d want 4 28 7",
               ldc[1] - l, cph[1] - h, rise1 - r);
    end
  endtask

  task automatic test_mid_toggle;
    int n;
    logic d0;
    d0 = done[0];
    par0 = 8'h3C;
    kick(0);
    repeat (10) @(posedge clk);
    #1;
    par0 = 8'hC3;
    tog[0] = ~tog[0];
    wait_done(0, 100, n);
    n = n + 10;
    checks++;
    if (n !== lat(1, 8) + 1) begin
      errors++; $display("FAIL mid_first_lat: got %0d want %0d", n, lat(1, 8) + 1);
    end
    checks++;
    if (val0 !== 8'h3C) begin
      errors++; $display("FAIL mid_first_value: got %h want 3c", val0);
    end
    wait_done(0, 100, n);
    checks++;
    if (n !== lat(1, 8) + 1) begin
      errors++; $display("FAIL mid_second_lat: got %0d want %0d", n, lat(1, 8) + 1);
    end
    checks++;
    if (val0 !== 8'hC3 || done[0] !== d0) begin
      errors++;
      $display("FAIL mid_second: got val=%h done=%b want c3 %b", val0, done[0], d0);
    end
    par0 = 8'h5A;
    kick(0);
    repeat (5) @(posedge clk);
    #1 tog[0] = ~tog[0];
    repeat (3) @(posedge clk);
    #1 tog[0] = ~tog[0];
    wait_done(0, 100, n);
    checks++;
    if (val0 !== 8'h5A) begin
      errors++; $display("FAIL dbl_value: got %h want 5a", val0);
    end
    wait_done(0, 60, n);
    checks++;
    if (n !== 60 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL dbl_no_read: got wait=%0d busy=%b want 60 0", n, busy[0]);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    par0 = 8'hF0;
    kick(0);
    repeat (14) @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    tog[0] = 1'b0;
    #1;
    checks++;
    if (ld[0] !== 1'b1 || cp[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL rmid_pins: got load_n=%b cp=%b busy=%b want 1 0 0",
               ld[0], cp[0], busy[0]);
    end
    checks++;
    if (val0 !== 8'h00 || done[0] !== 1'b0) begin
      errors++;
      $display("FAIL rmid_out: got val=%h done=%b want 00 0", val0, done[0]);
    end
    @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (5) @(posedge clk);
    par0 = 8'h96;
    kick(0);
    wait_done(0, 100, n);
    checks++;
    if (n !== lat(1, 8) + 1 || val0 !== 8'h96) begin
      errors++;
      $display("FAIL rmid_reread: got lat=%0d val=%h want %0d 96",
               n, val0, lat(1, 8) + 1);
    end
  endtask

  task automatic test_wide;
    int r, n;
    par2 = 16'hBEEF;
    r = rise2;
    kick(2);
    wait_done(2, 200, n);
    checks++;
    if (n !== lat(1, 16) + 1) begin
      errors++; $display("FAIL wide_latency: got %0d want %0d", n, lat(1, 16) + 1);
    end
    checks++;
    if (val2 !== 16'hBEEF) begin
      errors++; $display("FAIL wide_value: got %h want beef", val2);
    end
    checks++;
    if (rise2 - r !== 15) begin
      errors++; $display("FAIL wide_cp: got %0d want 15", rise2 - r);
    end
  endtask

  initial begin
    tog  = '0;
    par0 = '0;
    par1 = '0;
    par2 = '0;
    test_reset;
    test_basic;
    test_phase4;
    test_mid_toggle;
    test_reset_mid;
    test_wide;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
